// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the MIPS-Lite 5-stage pipeline: load-use stall,
// taken-branch squash, HALT drain, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int OPW       = 6,
  parameter int REGW      = 5,
  parameter int CNTW      = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            ex_br_taken,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state;
  logic [DW-1:0]   dcnt;
  logic            ex_ld_v;
  logic [REGW-1:0] ex_ld_rd;

  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] rs;
  logic [REGW-1:0] rt;
  logic            rd_rs;
  logic            rd_rt;
  logic            is_ldw;
  logic            is_halt;
  logic            load_use;
  logic            br_evt;
  logic            stall_evt;
  logic            halt_evt;
  logic            unused_bits;

  assign opcode      = id_instr[31 -: OPW];
  assign rs          = id_instr[31-OPW -: REGW];
  assign rt          = id_instr[31-OPW-REGW -: REGW];
  assign unused_bits = ^id_instr[31-OPW-2*REGW:0];

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Decode which source fields the ID instruction actually reads
  always_comb begin
    rd_rs   = 1'b0;
    rd_rt   = 1'b0;
    is_ldw  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OPW'(0), OPW'(2), OPW'(4), OPW'(6), OPW'(8), OPW'(10),
      OPW'(13), OPW'(15): begin
        rd_rs = 1'b1;
        rd_rt = 1'b1;
      end
      OPW'(1), OPW'(3), OPW'(5), OPW'(7), OPW'(9), OPW'(11),
      OPW'(14), OPW'(16): rd_rs = 1'b1;
      OPW'(12): begin
        rd_rs  = 1'b1;
        is_ldw = 1'b1;
      end
      OPW'(17): is_halt = 1'b1;
      default: ;
    endcase
  end

  assign load_use = id_valid & ex_ld_v &
                    ((rd_rs & (rs == ex_ld_rd)) | (rd_rt & (rt == ex_ld_rd)));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    br_evt      = 1'b0;
    stall_evt   = 1'b0;
    halt_evt    = 1'b0;
    if (state == RUN) begin
      if (ex_br_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        br_evt     = 1'b1;
      end else if (load_use) begin
        stall_evt = 1'b1;
      end else if (id_valid && is_halt) begin
        // HALT moves on to EX while nothing new is fetched behind it
        ifid_flush  = 1'b1;
        idex_bubble = 1'b0;
        halt_evt    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      dcnt      <= '0;
      ex_ld_v   <= 1'b0;
      ex_ld_rd  <= '0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_ld_v  <= id_valid & is_ldw & ~idex_bubble;
      ex_ld_rd <= rt;
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (br_evt)    flush_cnt <= sat_inc(flush_cnt);
      case (state)
        RUN: if (halt_evt) begin
          state <= DRAIN;
          dcnt  <= DW'(DRAIN_CYC - 1);
        end
        DRAIN: if (dcnt == '0) begin
          state  <= HALTED;
          halted <= 1'b1;
        end else begin
          dcnt <= dcnt - 1'b1;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use stalls, branch squash, HALT drain/freeze,
// reset out of DRAIN and counter saturation (CNTW=4).
module tb_hazard_ctrl;

  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic            ex_br_taken;
  logic            pc_en;
  logic            ifid_en;
  logic            ifid_flush;
  logic            idex_bubble;
  logic            halted;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.OPW(6), .REGW(5), .CNTW(CNTW), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_br_taken(ex_br_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int s, input int t, input int d);
    ins = {op[5:0], s[4:0], t[4:0], d[4:0], 11'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // settle the combinational outputs, then compare all four controls
  task automatic ctl(input string tag, input logic pe, input logic ie,
                     input logic fl, input logic bb);
    #1;
    chk({tag, ".pc_en"}, pc_en, pe);
    chk({tag, ".ifid_en"}, ifid_en, ie);
    chk({tag, ".ifid_flush"}, ifid_flush, fl);
    chk({tag, ".idex_bubble"}, idex_bubble, bb);
  endtask

  task automatic issue(input logic [31:0] i);
    id_valid = 1'b1;
    id_instr = i;
  endtask

  localparam int ADD = 0, ADDI = 1, LDW = 12, STW = 13, HALT = 17;

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_br_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ctl("reset", 1, 1, 0, 0);
    chk("reset.halted", halted, 0);
    chk("reset.stall_cnt", stall_cnt, 0);
    chk("reset.flush_cnt", flush_cnt, 0);

    // LDW R3,0(R1) then ADD R4,R3,R2: one stall cycle, then ADD proceeds
    issue(ins(LDW, 1, 3, 0));
    ctl("ldw", 1, 1, 0, 0);
    tick();
    issue(ins(ADD, 3, 2, 4));
    ctl("lu_add", 0, 0, 0, 1);
    tick();
    ctl("lu_add_go", 1, 1, 0, 0);
    chk("lu_add.stall_cnt", stall_cnt, 1);
    tick();

    // ADDI R5,R6,#4 and ADDI R3,R6,#4 (rt only written) do not stall
    issue(ins(LDW, 1, 3, 0)); tick();
    issue(ins(ADDI, 6, 5, 0));
    ctl("addi_nomatch", 1, 1, 0, 0);
    tick();
    issue(ins(LDW, 1, 3, 0)); tick();
    issue(ins(ADDI, 6, 3, 0));
    ctl("addi_rt_write", 1, 1, 0, 0);
    tick();
    chk("addi.stall_cnt", stall_cnt, 1);

    // STW R3 right after LDW R3: rt source match
    issue(ins(LDW, 1, 3, 0)); tick();
    issue(ins(STW, 1, 3, 0));
    ctl("stw_lu", 0, 0, 0, 1);
    tick();
    ctl("stw_go", 1, 1, 0, 0);
    chk("stw.stall_cnt", stall_cnt, 2);
    tick();

    // R0 compares like any register
    issue(ins(LDW, 1, 0, 0)); tick();
    issue(ins(ADD, 0, 7, 8));
    ctl("r0_lu", 0, 0, 0, 1);
    tick();
    chk("r0.stall_cnt", stall_cnt, 3);

    // Dependent but id_valid=0: no stall
    issue(ins(LDW, 1, 3, 0)); tick();
    id_valid = 1'b0; id_instr = ins(ADD, 3, 2, 4);
    ctl("novalid", 1, 1, 0, 0);
    tick();

    // Taken branch outranks a load-use in ID
    issue(ins(LDW, 1, 3, 0)); tick();
    issue(ins(ADD, 3, 2, 4)); ex_br_taken = 1'b1;
    ctl("br_lu", 1, 1, 1, 1);
    tick();
    ex_br_taken = 1'b0; id_valid = 1'b0;
    chk("br.flush_cnt", flush_cnt, 1);
    chk("br.stall_cnt", stall_cnt, 3);

    // Saturation: 12 more stalls reach 4'hF, further stalls hold
    for (int k = 0; k < 14; k++) begin
      issue(ins(LDW, 1, 3, 0)); tick();
      issue(ins(ADD, 2, 3, 4)); tick();
      if (k == 11) chk("sat.reach", stall_cnt, 4'hF);
    end
    chk("sat.hold", stall_cnt, 4'hF);

    // HALT, then reset while DRAIN has dcnt=1
    issue(ins(HALT, 0, 0, 0));
    ctl("halt_id", 0, 0, 1, 0);
    tick();
    id_valid = 1'b0;
    ctl("drain0", 0, 0, 0, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ctl("drain_rst", 1, 1, 0, 0);
    chk("drain_rst.halted", halted, 0);
    chk("drain_rst.stall_cnt", stall_cnt, 0);
    chk("drain_rst.flush_cnt", flush_cnt, 0);

    // One branch, then full HALT drain and freeze
    ex_br_taken = 1'b1; tick(); ex_br_taken = 1'b0;
    chk("br2.flush_cnt", flush_cnt, 1);
    issue(ins(HALT, 0, 0, 0));
    ctl("halt2_id", 0, 0, 1, 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      id_valid = 1'b0;
      ctl("drain", 0, 0, 0, 1);
      chk("drain.halted_low", halted, 0);
      tick();
    end
    chk("halted_rise", halted, 1);
    for (int k = 0; k < 8; k++) begin
      id_valid    = 1'($urandom_range(0, 1));
      ex_br_taken = 1'($urandom_range(0, 1));
      id_instr    = $urandom;
      ctl("frozen", 0, 0, 0, 1);
      tick();
      chk("frozen.halted", halted, 1);
      chk("frozen.flush_cnt", flush_cnt, 1);
      chk("frozen.stall_cnt", stall_cnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the MIPS-Lite 5-stage forwarding pipeline. It sits beside the ID stage and drives the PC, IF/ID and ID/EX enables and flushes. Forwarding covers every RAW hazard except load-use, so this block inserts that one-cycle stall, squashes wrong-path instructions on a taken branch or jump, and drains the pipeline on HALT. It also keeps saturating stall and flush counters for performance reporting.

## Interface
- OPW, 6, opcode field width
- REGW, 5, register index width
- CNTW, 32, performance counter width
- DRAIN_CYC, 3, cycles from HALT leaving ID until halted (EX, MEM, WB)
- clk  in  1  pipeline clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction (not a bubble)
- id_instr  in  32  Instruct currently in ID (opcode/rs/rt/rd fields)
- ex_br_taken  in  1  branch/JR in EX resolved taken this cycle
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID register loads a bubble
- idex_bubble  out  1  ID/EX register loads a bubble instead of the ID instruction
- halted  out  1  pipeline fully drained after HALT; sticky until rst
- stall_cnt  out  CNTW  load-use stall cycles, saturating
- flush_cnt  out  CNTW  taken-branch flush events, saturating

## Operation
- Decode of id_instr.opcode:
  - R-type ADD/SUB/MUL/OR/AND/XOR (00_0000, 00_0010, 00_0100, 00_0110, 00_1000, 00_1010) read rs and rt, and write rd.
  - I-type ADDI/SUBI/MULI/ORI/ANDI/XORI (odd opcodes 00_0001 to 00_1011) and LDW (00_1100) read rs and write rt.
  - STW (00_1101) and BEQ (00_1111) read rs and rt, and write nothing.
  - BZ (00_1110) and JR (01_0000) read rs only.
  - HALT (01_0001) and undefined opcodes read and write nothing.
- R0 is an ordinary register and is compared like any other.
- EX tracker registers: ex_ld_v (1) and ex_ld_rd (REGW).
  - Each cycle, ex_ld_v <= id_valid & (opcode == LDW) & ~idex_bubble, and ex_ld_rd <= the LDW rt field.
  - When idex_bubble is 1, ex_ld_v <= 0.
- load_use = id_valid & ex_ld_v & (ID reads rs and rs == ex_ld_rd, or ID reads rt and rt == ex_ld_rd).
- FSM states RUN, DRAIN, HALTED, plus a drain counter dcnt (2 bits, sized for DRAIN_CYC).
  - RUN, priority order:
    1. ex_br_taken: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1, flush_cnt+1. Any load-use or HALT in ID is squashed.
    2. load_use: pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt+1.
    3. id_valid & HALT: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=0 so HALT advances to EX. Next state DRAIN with dcnt=DRAIN_CYC-1.
    4. Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
  - DRAIN: pc_en=0, ifid_en=0, idex_bubble=1; ex_br_taken and load_use are ignored. dcnt decrements each cycle; when dcnt==0, next state is HALTED.
  - HALTED: same outputs as DRAIN, halted=1. Only rst exits this state.
- Counters saturate at all-ones and hold there.

## Timing
- Control outputs (pc_en, ifid_en, ifid_flush, idex_bubble) are combinational from the current state, the tracker registers and the same-cycle inputs. They act on the next clk edge.
- halted, the counters, the tracker registers and the FSM state are registered.
- Load-use penalty is exactly 1 cycle. After the stall, ex_ld_v=0, so the same ID instruction proceeds and takes its operand from MEM/WB forwarding.
- Taken-branch penalty is 2 squashed instructions (IF/ID and ID/EX).
- halted rises DRAIN_CYC cycles after the edge at which HALT left ID.
- Reset values: state=RUN, dcnt=0, ex_ld_v=0, ex_ld_rd=0, halted=0, stall_cnt=0, flush_cnt=0. After reset the control outputs are therefore pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0 (given id_valid=0 or no hazard).
- rst during DRAIN or HALTED returns to RUN on the next edge and clears the counters. rst has priority over all other events.

## Test plan
- LDW R3,0(R1), then ADD R4,R3,R2: exactly one cycle with pc_en=0 and idex_bubble=1, stall_cnt=1; the ADD enters EX on the following cycle.
- LDW R3, then ADDI R5,R6,#4 (no match), and STW R3 immediately after LDW R3 (rt match): the ADDI causes no stall; the STW gives 1 stall.
- ex_br_taken=1 on the same cycle that ID holds a load-use dependent: ifid_flush=1, idex_bubble=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- HALT reaches ID in RUN: pc_en=0 from that cycle on, halted=1 exactly 3 cycles after HALT enters EX, and the outputs stay frozen under random id_valid and ex_br_taken.
- Assert rst for 1 cycle while in DRAIN (dcnt=1): halted=0, counters 0, pc_en=1 on the next cycle.
- Force stall_cnt to all-ones with CNTW=4, then apply further load-use stalls: stall_cnt holds at 4'hF.
